// File: rtl/seg_calc_n.sv
// Two-operand add/subtract calculator driving a scanned hex seven-segment display.
// Operands are latched from switches on key pulses; calc produces {flag,R}; view selects what is shown.
module seg_calc_n #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  sw,
  input  logic              load_a,
  input  logic              load_b,
  input  logic              calc,
  input  logic              sub_mode,
  output logic [8:0]        seg_led,
  output logic [DIGITS-1:0] dig_sel,
  output logic              flag,
  output logic [1:0]        view
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = DIGITS * 4;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     LAST_IDX  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_RST   = ~(DIGITS'(1));

  typedef enum logic [1:0] {
    SHOW_A   = 2'd0,
    SHOW_B   = 2'd1,
    SHOW_RES = 2'd2
  } view_t;

  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, r_q, r_d;
  logic              flag_q, flag_d;
  view_t             view_q, view_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [8:0]        seg_q, seg_d;

  logic [WIDTH:0]    sum_w, diff_w;
  logic [DW-1:0]     disp_val;
  logic [3:0]        nib;
  logic              dp;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] c;
    c = 7'h00;
    case (n)
      4'h0: c = 7'h3F;  4'h1: c = 7'h06;  4'h2: c = 7'h5B;  4'h3: c = 7'h4F;
      4'h4: c = 7'h66;  4'h5: c = 7'h6D;  4'h6: c = 7'h7D;  4'h7: c = 7'h07;
      4'h8: c = 7'h7F;  4'h9: c = 7'h6F;  4'hA: c = 7'h77;  4'hB: c = 7'h7C;
      4'hC: c = 7'h39;  4'hD: c = 7'h5E;  4'hE: c = 7'h79;  default: c = 7'h71;
    endcase
    return c;
  endfunction

  // Key handling: calc wins over any load in the same cycle.
  // The borrow falls out as the top bit of a WIDTH+1-bit difference.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    r_d    = r_q;
    flag_d = flag_q;
    view_d = view_q;
    sum_w  = {1'b0, a_q} + {1'b0, b_q};
    diff_w = {1'b0, a_q} - {1'b0, b_q};
    if (calc) begin
      {flag_d, r_d} = sub_mode ? diff_w : sum_w;
      view_d        = SHOW_RES;
    end else begin
      if (load_a) begin
        a_d    = sw;
        view_d = SHOW_A;
      end
      if (load_b) begin
        b_d    = sw;
        view_d = SHOW_B;
      end
    end
  end

  // Scanning: seg_led and dig_sel both derive from idx_q on the same edge.
  always_comb begin
    presc_d   = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    if (presc_q == PRESC_MAX)
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    dig_sel_d        = '1;
    dig_sel_d[idx_q] = 1'b0;
    disp_val = '0;
    case (view_q)
      SHOW_A:   disp_val[WIDTH-1:0] = a_q;
      SHOW_B:   disp_val[WIDTH-1:0] = b_q;
      SHOW_RES: disp_val[WIDTH:0]   = {flag_q, r_q};
      default:  disp_val = '0;
    endcase
    nib   = disp_val[idx_q*4 +: 4];
    dp    = (idx_q == LAST_IDX) && (view_q == SHOW_RES) && flag_q;
    seg_d = {1'b0, dp, hex7(nib)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      flag_q    <= 1'b0;
      view_q    <= SHOW_A;
      presc_q   <= '0;
      idx_q     <= '0;
      dig_sel_q <= DIG_RST;
      seg_q     <= 9'h03F;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      flag_q    <= flag_d;
      view_q    <= view_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      dig_sel_q <= dig_sel_d;
      seg_q     <= seg_d;
    end
  end

  assign seg_led = seg_q;
  assign dig_sel = dig_sel_q;
  assign flag    = flag_q;
  assign view    = view_q;

endmodule

// File: tb/tb_seg_calc_n.sv
// Bench for seg_calc_n (WIDTH=8, DIGITS=3, SCAN_DIV=4): a reference model predicts
// operands, result and display codes; calc results go through an expected queue.
module tb_seg_calc_n;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sw = '0;
  logic       load_a = 1'b0, load_b = 1'b0, calc = 1'b0, sub_mode = 1'b0;
  logic [8:0] seg_led;
  logic [2:0] dig_sel;
  logic       flag;
  logic [1:0] view;

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];

  logic [7:0] m_a = '0, m_b = '0;
  logic [1:0] m_view = '0;
  logic [8:0] m_res = '0;

  seg_calc_n #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .sw(sw), .load_a(load_a), .load_b(load_b),
    .calc(calc), .sub_mode(sub_mode), .seg_led(seg_led), .dig_sel(dig_sel),
    .flag(flag), .view(view)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] code(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  // One key cycle; the model follows the same cycle's inputs.
  task automatic key(input logic la, input logic lb, input logic c, input logic sm,
                     input logic [7:0] v);
    int s;
    @(negedge clk);
    sw = v; load_a = la; load_b = lb; calc = c; sub_mode = sm;
    if (c) begin
      if (sm) begin
        m_res = {(m_a < m_b) ? 1'b1 : 1'b0, 8'(m_a - m_b)};
      end else begin
        s = int'(m_a) + int'(m_b);
        m_res = {(s > 255) ? 1'b1 : 1'b0, 8'(s)};
      end
      exp_q.push_back(m_res);
      m_view = 2'd2;
    end else begin
      if (la) begin m_a = v; m_view = 2'd0; end
      if (lb) begin m_b = v; m_view = 2'd1; end
    end
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0; calc = 1'b0;
  endtask

  task automatic check_digits(input string name, input logic [11:0] val, input logic dp_top);
    int n;
    logic [2:0] want_sel;
    logic [8:0] want;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n = 0;
      want_sel = ~(3'b001 << d);
      while (dig_sel !== want_sel && n < 20) begin
        @(negedge clk);
        n++;
      end
      want = {1'b0, (d == 2) && dp_top, code(val[4*d +: 4])};
      total++;
      if (dig_sel !== want_sel) begin
        bad++;
        $display("FAIL %s digit%0d: dig_sel=%b never reached %b", name, d, dig_sel, want_sel);
      end else if (seg_led !== want) begin
        bad++;
        $display("FAIL %s digit%0d: seg_led=%h expected %h", name, d, seg_led, want);
      end
    end
  endtask

  task automatic check_state(input string name);
    logic [11:0] val;
    val = (m_view == 2'd0) ? {4'h0, m_a} : (m_view == 2'd1) ? {4'h0, m_b} : {3'b0, m_res};
    repeat (2) @(negedge clk);
    total++;
    if (view !== m_view) begin
      bad++;
      $display("FAIL %s view: got %0d expected %0d", name, view, m_view);
    end
    total++;
    if (flag !== m_res[8]) begin
      bad++;
      $display("FAIL %s flag: got %b expected %b", name, flag, m_res[8]);
    end
    check_digits(name, val, (m_view == 2'd2) && m_res[8]);
  endtask

  task automatic check_result(input string name);
    logic [8:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no expected result queued", name);
    end else begin
      e = exp_q.pop_front();
      repeat (2) @(negedge clk);
      if (view !== 2'd2 || flag !== e[8]) begin
        bad++;
        $display("FAIL %s result: view=%0d flag=%b expected view=2 flag=%b", name, view, flag, e[8]);
      end
      check_digits(name, {3'b0, e}, e[8]);
    end
  endtask

  task automatic test_reset();
    int want_idx;
    repeat (2) @(negedge clk);
    total++;
    if (seg_led !== 9'h03F || dig_sel !== 3'b110 || view !== 2'd0 || flag !== 1'b0) begin
      bad++;
      $display("FAIL reset: seg=%h sel=%b view=%0d flag=%b expected 03f 110 0 0",
               seg_led, dig_sel, view, flag);
    end
    rst = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      want_idx = ((n - 1) / 4) % 3;
      total++;
      if (dig_sel !== ~(3'b001 << want_idx)) begin
        bad++;
        $display("FAIL scan cycle%0d: dig_sel=%b expected %b", n, dig_sel, ~(3'b001 << want_idx));
      end
    end
  endtask

  task automatic test_load();
    key(1, 0, 0, 0, 8'hA5);
    check_state("load_a");
    key(0, 1, 0, 0, 8'h3C);
    check_state("load_b");
  endtask

  task automatic test_add();
    key(0, 0, 1, 0, 8'h00);
    check_result("add_e1");
    key(1, 0, 0, 0, 8'hFF);
    key(0, 1, 0, 0, 8'h01);
    key(0, 0, 1, 0, 8'h00);
    check_result("add_carry");
  endtask

  task automatic test_sub_priority();
    key(1, 0, 0, 0, 8'h05);
    key(0, 1, 0, 0, 8'h07);
    key(1, 0, 1, 1, 8'h99);
    check_result("sub_borrow");
    key(0, 0, 1, 0, 8'h00);
    check_result("add_after_prio");
    key(1, 0, 0, 0, 8'h33);
    check_state("load_after_calc");
    key(0, 0, 1, 1, 8'h00);
    check_result("sub_repeat");
  endtask

  task automatic test_both_load_reset();
    int n;
    key(1, 1, 0, 0, 8'h12);
    check_state("load_both");
    n = 0;
    while (dig_sel !== 3'b011 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (seg_led !== 9'h03F || dig_sel !== 3'b110 || view !== 2'd0 || flag !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: seg=%h sel=%b view=%0d flag=%b expected 03f 110 0 0",
               seg_led, dig_sel, view, flag);
    end
    m_a = '0; m_b = '0; m_res = '0; m_view = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    check_state("after_reset");
  endtask

  initial begin
    test_reset();
    test_load();
    test_add();
    test_sub_priority();
    test_both_load_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_calc_n.md
Name: seg_calc_n

Overview:
- Parametrised successor to the single-digit 4-bit switch adder.
- Latches two WIDTH-bit operands from switches on debounced key pulses, then computes A+B or A−B on a calc pulse.
- Shows operand A, operand B or the result as hex on a DIGITS-wide, time-multiplexed 7-segment display.
- Sits between the team's debounce block (key pulses in) and the board's scanned seven-segment pins.

Parameters:
- WIDTH, 8: operand width in bits, 4..16.
- DIGITS, 3: number of scanned display digits. Must satisfy DIGITS*4 >= WIDTH+1.
- SCAN_DIV, 50000: clk cycles per digit slot. Must be >= 2.

Ports:
- clk  in  1: system clock.
- rst  in  1: asynchronous, active-low reset.
- sw  in  WIDTH: operand switches.
- load_a  in  1: single-cycle debounced pulse; latch sw into A.
- load_b  in  1: single-cycle debounced pulse; latch sw into B.
- calc  in  1: single-cycle debounced pulse; compute result.
- sub_mode  in  1: level signal sampled on calc. 0 = add, 1 = subtract.
- seg_led  out  9: segment pattern. Bits [6:0] = g..a, bit 7 = dp, bit 8 always 0. Active-high.
- dig_sel  out  DIGITS: one-hot, active-low digit enable. Bit 0 = least-significant digit.
- flag  out  1: carry (add) or borrow (sub) from the last calc.
- view  out  2: display state. 0 = SHOW_A, 1 = SHOW_B, 2 = SHOW_RES.

Behaviour:
Reset (async, rst=0):
- A=0, B=0, result=0, flag=0, view=SHOW_A.
- Prescaler=0, digit index=0.
- dig_sel = all ones except bit 0 = 0.
- seg_led = 9'h03F.

Registers:
- A[WIDTH-1:0], B[WIDTH-1:0], R[WIDTH-1:0], flag.

Key events:
- load_a: A <= sw, view <= SHOW_A, next cycle.
- load_b: B <= sw, view <= SHOW_B, next cycle.
- load_a and load_b in the same cycle: both load; view <= SHOW_B.
- calc: {flag,R} <= A+B (WIDTH+1-bit sum) when sub_mode=0.
- calc: R <= (A−B) mod 2^WIDTH, flag <= (A<B) when sub_mode=1.
- calc: view <= SHOW_RES. Latency is 1 cycle.
- calc uses the A/B values registered before that edge.
- calc has priority: any load pulse in the same cycle is ignored.
- Repeated calc recomputes from the current A/B and sub_mode.
- Loads after a calc do not alter R or flag until the next calc.

Display value (zero-extended to DIGITS*4 bits):
- SHOW_A: A.
- SHOW_B: B.
- SHOW_RES: {flag,R}.

Scanning:
- Prescaler counts 0..SCAN_DIV-1 and wraps.
- On wrap, digit index increments modulo DIGITS (DIGITS-1 -> 0).
- dig_sel is registered from the index: bit idx = 0, all others 1.
- seg_led is registered each cycle from the current index and current display value:
  - nibble = value[4*idx+3 : 4*idx]
  - hex code table: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71
  - bit 7 (dp) = 1 only when idx = DIGITS-1, view = SHOW_RES and flag = 1.
- Leading zeros are displayed, not blanked.
- A change in view or value appears on seg_led 1 cycle after the register update, i.e. 2 cycles after the key pulse.
- seg_led and dig_sel always change on the same edge, so there is no ghosting across slots.

Reset mid-operation:
- Immediately returns all state to reset values.
- Scanning restarts at digit 0.

Test Plan (WIDTH=8, DIGITS=3, SCAN_DIV=4):
1. Reset released with no keys pressed -> seg_led=03F, dig_sel=110, view=0, flag=0. Digit index advances every 4 clk: dig_sel 110 -> 101 -> 011 -> 110.
2. sw=8'hA5, load_a; sw=8'h3C, load_b -> view=1. Scan shows nibbles C,3,0 (codes 39,4F,3F).
3. From scenario 2, sub_mode=0, calc -> R=8'hE1, flag=0, view=2. Digits 1,E,0 (06,79,3F), dp off.
4. A=8'hFF, B=8'h01, add calc -> R=00, flag=1. Digit 2 shows 06 with dp set (seg_led=0x086).
5. A=8'h05, B=8'h07, sub_mode=1, calc -> R=8'hFE, flag=1. Same cycle calc+load_a with sw=8'h99: A stays 05, result matches calc-only.
6. load_a and load_b together with sw=8'h12 -> A=B=12, view=1. rst pulsed mid-scan at index 2 -> all outputs return to reset values asynchronously.
